dequ_extract_ctrl: RTL
======================

Name: dequ_extract_ctrl

Overview:
Sequencer for the asynchronous barrel-shifter bit extractor in the parallel dequantizer. Accepts 512-bit packed code lines and walks a bit offset through each line, driving the shifter's line, offset and width inputs. It resolves outlier escapes, where an all-ones code is followed by a raw OWIDTH-bit value, and emits one registered code per handshake until a frame of cfg_num_codes codes is complete.

Parameters:
L2WIDTH, 512, packed line width in bits
WWIDTH, 32, shifter extraction window / output code width
SWIDTH, 5, code-width field width
OFFW, 9, shifter offset width (log2 L2WIDTH)
OWIDTH, 16, raw escape value width (must be <= WWIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  frame start pulse; ignored while busy
cfg_code_width  in  SWIDTH  code width in bits; 0 is treated as 1
cfg_num_codes  in  16  codes per frame
busy  out  1  frame in progress
done  out  1  one-cycle frame-complete pulse
line_in  in  L2WIDTH  packed line
line_valid  in  1  line_in valid
line_ready  out  1  controller accepts a line
shf_line  out  L2WIDTH  held line to shifter InputStr
shf_acc_shift  out  OFFW  bit offset to shifter AccNumShift
shf_num_shift  out  SWIDTH  width to shifter NumShift
shf_bits  in  WWIDTH  shifter ExtractedBits (combinational return)
shf_outlier  in  1  shifter IsOutlier
out_code  out  WWIDTH  extracted code or escape value
out_is_esc  out  1  out_code is a raw escape value
out_valid  out  1  output valid
out_ready  in  1  downstream accept

Behaviour:
- Reset (synchronous, active-high, on clk): state IDLE. busy, done, line_ready, out_valid and out_is_esc are 0. out_code, shf_line, shf_acc_shift and the internal offset are 0. A held line is discarded. Reset mid-frame aborts the frame; done is not pulsed.
- Output slot: single register. The slot is free when out_valid=0 or out_ready=1. An emit only happens in a cycle where the slot is free. out_valid drops after a handshake with no new emit.
- Internal offset: OFFW+1 bits. shf_acc_shift = offset[OFFW-1:0].
- IDLE:
  - start latches cw = max(cfg_code_width, 1) and codes_left = cfg_num_codes.
  - If codes_left = 0, done pulses next cycle and the block stays in IDLE.
  - Otherwise go to FETCH. busy = 1 in every state except IDLE.
- FETCH:
  - line_ready = 1.
  - On line_valid: load shf_line, set offset = 0, go to ESC if esc_pend, else CODE.
- CODE (shf_num_shift = cw):
  - If offset+cw > L2WIDTH, go to FETCH; the line tail is discarded and no codes straddle lines.
  - Else, if the slot is free and shf_outlier = 1: offset += cw, go to ESC, no emit.
  - Else, if the slot is free: out_code = shf_bits, out_is_esc = 0, out_valid = 1, offset += cw, codes_left -= 1. Go to DONE if codes_left reaches 0.
  - If the slot is not free, hold.
- ESC (shf_num_shift = 0, which yields the raw unmasked slice):
  - If offset+OWIDTH > L2WIDTH: set esc_pend, go to FETCH.
  - Else, if the slot is free: out_code = zero-extended shf_bits[OWIDTH-1:0], out_is_esc = 1, out_valid = 1, offset += OWIDTH, codes_left -= 1, clear esc_pend. Go to CODE, or DONE if codes_left = 0.
- DONE: wait until out_valid=0 or out_ready=1, pulse done for 1 cycle, go to IDLE.
- An escape marker does not count as a code; the escape value counts as one code.
- An offset landing exactly on L2WIDTH is legal: the next extraction fetches.
- start during busy has no effect.

Optional Feature:
DEQU_PERF_CNT_EN:
- Defined: 16-bit saturating outputs perf_esc_cnt (escape values emitted) and perf_stall_cnt (cycles in CODE/ESC with the slot not free). Both clear on rst and on an accepted start.
- Undefined: both ports exist and are tied 0, and no counter logic is present.

Test Plan:
- cw=4, num_codes=3, line with low nibbles 0x1, 0x2, 0x3, out_ready=1. The bench's shifter model returns the slice as data with the outlier flag 0, so out_code carries the slice. Required: three emits in consecutive cycles at offsets 0, 4, 8, then the done pulse, then busy=0.
- cw=4, line bits[3:0]=0xF with shf_outlier=1 and bits[19:4]=0xBEEF, num_codes=1. Required: shf_acc_shift=0 then 4, shf_num_shift=0 in ESC, out_code=0x0000BEEF with out_is_esc=1, done.
- cw=31, num_codes=17. Required: 16 codes from line 0 (offset 496+31 > 512 forces FETCH), then code 17 at offset 0 of line 1.
- Escape marker ending at bit 500 (500+16 > 512). Required: line_ready asserted, then on the next line the ESC value is read at offset 0 with out_is_esc=1.
- out_ready held 0 for 5 cycles mid-frame. Required: out_code stable, offset frozen, no lost codes; with DEQU_PERF_CNT_EN, perf_stall_cnt=5.
- rst asserted during CODE. Required: next cycle busy=0, out_valid=0, line_ready=0, no done; a new start with num_codes=0 gives done one cycle later.

Source files
------------

// File: rtl/dequ_extract_ctrl.sv
// Bit-offset sequencer for the dequantizer barrel-shifter extractor: walks each packed line, resolves escapes.
// Optional build macro DEQU_PERF_CNT_EN adds escape / stall performance counters.
module dequ_extract_ctrl #(
    parameter int L2WIDTH = 512,
    parameter int WWIDTH  = 32,
    parameter int SWIDTH  = 5,
    parameter int OFFW    = 9,
    parameter int OWIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SWIDTH-1:0]  cfg_code_width,
    input  logic [15:0]        cfg_num_codes,
    output logic               busy,
    output logic               done,
    input  logic [L2WIDTH-1:0] line_in,
    input  logic               line_valid,
    output logic               line_ready,
    output logic [L2WIDTH-1:0] shf_line,
    output logic [OFFW-1:0]    shf_acc_shift,
    output logic [SWIDTH-1:0]  shf_num_shift,
    input  logic [WWIDTH-1:0]  shf_bits,
    input  logic               shf_outlier,
    output logic [WWIDTH-1:0]  out_code,
    output logic               out_is_esc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        perf_esc_cnt,
    output logic [15:0]        perf_stall_cnt,
    output logic [2:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and payload is held stable while valid && !ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CODE  = 3'd2,
        S_ESC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SWIDTH-1:0]  cw_q, cw_d;
    logic [15:0]        codes_left_q, codes_left_d;
    logic [OFFW:0]      offset_q, offset_d;
    logic [L2WIDTH-1:0] line_q, line_d;
    logic               esc_pend_q, esc_pend_d;
    logic [WWIDTH-1:0]  out_code_q, out_code_d;
    logic               out_is_esc_q, out_is_esc_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;

    logic               slot_free;
    logic [OFFW+1:0]    code_end, esc_end;
    logic               code_over, esc_over;

    // One extra bit keeps the end-of-slice sums from wrapping.
    assign code_end  = {1'b0, offset_q} + (OFFW+2)'(cw_q);
    assign esc_end   = {1'b0, offset_q} + (OFFW+2)'(OWIDTH);
    assign code_over = code_end > (OFFW+2)'(L2WIDTH);
    assign esc_over  = esc_end > (OFFW+2)'(L2WIDTH);
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d       = state_q;
        cw_d          = cw_q;
        codes_left_d  = codes_left_q;
        offset_d      = offset_q;
        line_d        = line_q;
        esc_pend_d    = esc_pend_q;
        out_code_d    = out_code_q;
        out_is_esc_d  = out_is_esc_q;
        out_valid_d   = out_valid_q && !out_ready;
        done_d        = 1'b0;
        line_ready    = 1'b0;
        shf_num_shift = cw_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cw_d         = (cfg_code_width == '0) ? SWIDTH'(1) : cfg_code_width;
                    codes_left_d = cfg_num_codes;
                    esc_pend_d   = 1'b0;
                    if (cfg_num_codes == 16'd0) done_d = 1'b1;
                    else                        state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                line_ready = 1'b1;
                if (line_valid) begin
                    line_d   = line_in;
                    offset_d = '0;
                    state_d  = esc_pend_q ? S_ESC : S_CODE;
                end
            end
            S_CODE: begin
                if (code_over) begin
                    state_d = S_FETCH;
                end else if (slot_free) begin
                    offset_d = code_end[OFFW:0];
                    if (shf_outlier) begin
                        state_d = S_ESC;
                    end else begin
                        out_code_d   = shf_bits;
                        out_is_esc_d = 1'b0;
                        out_valid_d  = 1'b1;
                        codes_left_d = codes_left_q - 16'd1;
                        if (codes_left_q == 16'd1) state_d = S_DONE;
                    end
                end
            end
            S_ESC: begin
                // Width 0 makes the shifter return the raw unmasked window.
                shf_num_shift = '0;
                if (esc_over) begin
                    esc_pend_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (slot_free) begin
                    out_code_d   = WWIDTH'(shf_bits[OWIDTH-1:0]);
                    out_is_esc_d = 1'b1;
                    out_valid_d  = 1'b1;
                    offset_d     = esc_end[OFFW:0];
                    codes_left_d = codes_left_q - 16'd1;
                    esc_pend_d   = 1'b0;
                    state_d      = (codes_left_q == 16'd1) ? S_DONE : S_CODE;
                end
            end
            S_DONE: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cw_q         <= '0;
            codes_left_q <= '0;
            offset_q     <= '0;
            line_q       <= '0;
            esc_pend_q   <= 1'b0;
            out_code_q   <= '0;
            out_is_esc_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cw_q         <= cw_d;
            codes_left_q <= codes_left_d;
            offset_q     <= offset_d;
            line_q       <= line_d;
            esc_pend_q   <= esc_pend_d;
            out_code_q   <= out_code_d;
            out_is_esc_q <= out_is_esc_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign shf_line      = line_q;
    assign shf_acc_shift = offset_q[OFFW-1:0];
    assign out_code      = out_code_q;
    assign out_is_esc    = out_is_esc_q;
    assign out_valid     = out_valid_q;
    assign dbg_state     = state_q;

`ifdef DEQU_PERF_CNT_EN
    logic [15:0] perf_esc_q, perf_esc_d, perf_stall_q, perf_stall_d;
    logic        start_acc, esc_emit, stall;

    assign start_acc = (state_q == S_IDLE) && start;
    assign esc_emit  = (state_q == S_ESC) && !esc_over && slot_free;
    assign stall     = ((state_q == S_CODE) || (state_q == S_ESC)) && !slot_free;

    always_comb begin
        perf_esc_d   = perf_esc_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_esc_d   = '0;
            perf_stall_d = '0;
        end else begin
            if (esc_emit && (perf_esc_q != 16'hFFFF))  perf_esc_d   = perf_esc_q + 16'd1;
            if (stall && (perf_stall_q != 16'hFFFF))   perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_esc_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_esc_q   <= perf_esc_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_esc_cnt   = perf_esc_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_esc_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
